// File: rtl/alu_divider.sv
// ---------------------------------------------------------------------------
// alu_divider
//   Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   It divides operand magnitudes, producing one quotient bit per cycle, and
//   applies the sign fix-up in a final cycle. The busy output holds the
//   control FSM until the result is final.
//
// Handshake: an operation is accepted at a rising edge where op_valid=1 and
//   the unit is idle (busy=0). busy is high from the cycle after acceptance
//   until the cycle before done. done is a single-cycle pulse in the first
//   idle cycle, and result is valid from that cycle until the next operation
//   completes. op_valid while busy=1 is ignored. op_valid in the done cycle
//   starts a new operation.
//
// Ports
//   clk        in   1      core clock, rising edge
//   reset      in   1      asynchronous, active-low
//   op_valid   in   1      start request
//   funct3     in   3      100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1        in   WIDTH  dividend
//   rs2        in   WIDTH  divisor
//   busy       out  1      operation in flight
//   done       out  1      result-ready pulse
//   result     out  WIDTH  quotient or remainder
//   dbg_state  out  2      current FSM state (0 IDLE, 1 RUN, 2 FIX)
// ---------------------------------------------------------------------------
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH:0]   r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_special;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    // Operand decode at accept
    logic             w_signed;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic             w_accept;
    logic [WIDTH:0]   w_abs1;
    logic [WIDTH:0]   w_abs2;

    // One restoring step
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_fix_val;

    logic             w_unused;

    assign w_signed   = ~funct3[0];
    assign w_div_zero = (rs2 == '0);
    assign w_ovf      = w_signed && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
    assign w_special  = w_div_zero || w_ovf;
    assign w_accept   = op_valid && (r_state == IDLE);

    // Magnitudes are one bit wider so that |-2^(WIDTH-1)| is representable.
    assign w_abs1 = (w_signed && rs1[WIDTH-1]) ? (~{1'b1, rs1} + 1'b1) : {1'b0, rs1};
    assign w_abs2 = (w_signed && rs2[WIDTH-1]) ? (~{1'b1, rs2} + 1'b1) : {1'b0, rs2};

    // The partial remainder is always below the divisor, so it fits in WIDTH bits.
    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = {1'b0, w_shifted} - {1'b0, r_div};
    assign w_ge      = ~w_diff[WIDTH+1];

    // Special results are preloaded exactly and must not be sign-adjusted.
    always_comb begin
        w_fix_val = '0;
        if (r_is_rem) begin
            w_fix_val = (r_neg_r && !r_special) ? (~r_rem + 1'b1) : r_rem;
        end else begin
            w_fix_val = (r_neg_q && !r_special) ? (~r_quo + 1'b1) : r_quo;
        end
    end

    assign w_unused = funct3[2] | w_abs1[WIDTH] | w_diff[WIDTH];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (op_valid) begin
                    w_next_state = w_special ? FIX : RUN;
                end
            end
            RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next_state = FIX;
                end
            end
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (r_state == RUN) || (r_state == FIX);
        dbg_state = r_state;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done <= (r_state == FIX);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_rem  <= funct3[1];
                        r_neg_q   <= w_signed && (rs1[WIDTH-1] ^ rs2[WIDTH-1]);
                        r_neg_r   <= w_signed && rs1[WIDTH-1];
                        r_special <= w_special;
                        r_cnt     <= '0;
                        r_div     <= w_abs2;
                        if (w_div_zero) begin
                            r_quo <= '1;
                            r_rem <= rs1;
                        end else if (w_ovf) begin
                            r_quo <= rs1;
                            r_rem <= '0;
                        end else begin
                            r_quo <= w_abs1[WIDTH-1:0];
                            r_rem <= '0;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_result <= w_fix_val;
                end
                default: ;
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_alu_divider.sv
module tb_alu_divider;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         op_valid;
    logic [2:0]   funct3;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [1:0]   dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_cmp;
    int           n_fail;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    alu_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V division semantics, independent of the iterative datapath.
    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int sa;
        int sb;
        if (b == '0) return f[1] ? a : '1;
        if (!f[0] && a == 32'h8000_0000 && b == '1) return f[1] ? '0 : a;
        if (!f[0]) begin
            sa = $signed(a);
            sb = $signed(b);
            return f[1] ? W'(sa % sb) : W'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge. Drives one op, counts busy cycles, checks the
    // popped expected result when done appears. poke_at>0 re-pulses op_valid
    // at that busy cycle with junk operands. b2b returns in the done cycle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp,
                          input int poke_at, input bit b2b);
        int cycles;
        int lat;
        logic [W-1:0] e;
        lat = (b == '0 || (!f[0] && a == 32'h8000_0000 && b == '1)) ? 1 : W + 1;
        exp_q.push_back(exp);
        op_valid = 1'b1;
        funct3   = f;
        rs1      = a;
        rs2      = b;
        @(negedge clk);
        op_valid = 1'b0;
        cycles   = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            if (cycles == poke_at) begin
                op_valid = 1'b1;
                rs1      = $urandom;
                rs2      = W'($urandom_range(1, 9));
            end else begin
                op_valid = 1'b0;
            end
            @(negedge clk);
        end
        op_valid = 1'b0;
        chk({tag, ".latency"}, W'(cycles), W'(lat));
        chk({tag, ".done"}, W'(done), W'(1));
        e = exp_q.pop_front();
        chk({tag, ".result"}, result, e);
        if (!b2b) begin
            @(negedge clk);
            chk({tag, ".done_pulse"}, W'(done), W'(0));
            chk({tag, ".hold"}, result, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]   rf;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b0;
        op_valid = 1'b0;
        funct3   = 3'b000;
        rs1      = '0;
        rs2      = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", W'(busy), W'(0));
        chk("reset.done", W'(done), W'(0));
        chk("reset.result", result, '0);
        chk("reset.state", W'(dbg_state), W'(0));
        reset = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 0, 1'b0);
        run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 32'd5, 0, 1'b0);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
        run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
        run_op("divu_big", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("remu_big", F_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b0);
        run_op("div_min_2", F_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 0, 1'b0);
        run_op("rem_7_m2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, 1'b0);
        run_op("divu_poke", F_DIVU, 32'd1000, 32'd7, 32'd142, 10, 1'b0);

        // Back-to-back: second op issued in the first op's done cycle.
        run_op("b2b_a", F_DIVU, 32'd50, 32'd5, 32'd10, 0, 1'b1);
        run_op("b2b_b", F_REMU, 32'd50, 32'd7, 32'd1, 0, 1'b0);

        // Reset in the middle of an operation.
        op_valid = 1'b1;
        funct3   = F_DIVU;
        rs1      = 32'd77;
        rs2      = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort.busy", W'(busy), W'(0));
        chk("abort.result", result, '0);
        chk("abort.done", W'(done), W'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, 0, 1'b0);

        // Random operations against the reference model.
        for (int i = 0; i < 10; i++) begin
            rf = {1'b1, 2'($urandom_range(0, 3))};
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if ($urandom_range(0, 1) == 1) rb = W'($urandom_range(1, 1000));
            run_op("random", rf, ra, rb, model(rf, ra, rb), 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
